// File: rtl/alu_mux_pkg.sv
// Shared slot encoding and FSM state for the ALU 8:1 mux and TDM demux.
// The demux slot index maps directly onto the mux selects {S2,S1,S0}.
package alu_mux_pkg;

   localparam int DEF_N_SLOTS = 8;
   localparam int DEF_SEL_W   = $clog2(DEF_N_SLOTS);

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: load-to-1 on sync, step per beat, wrap to 0 after
// the last slot, with a last-slot flag for frame completion.
module tdm_slot_counter
   import alu_mux_pkg::*;
#(
   parameter int N_SLOTS = DEF_N_SLOTS,
   parameter int SEL_W   = $clog2(N_SLOTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             inc_i,
   output logic [SEL_W-1:0] slot_o,
   output logic             last_o
);

   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;

   assign last_o = (cnt_q == SEL_W'(N_SLOTS - 1));
   assign slot_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = SEL_W'(1);
      end else if (inc_i) begin
         cnt_d = last_o ? '0 : cnt_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tdm_demux_1to8.sv
// Serial-to-parallel TDM demux: beat k of a sync-aligned frame lands in
// dout[k]; partial frames interrupted by sync are dropped with frame_err.
module tdm_demux_1to8
   import alu_mux_pkg::*;
#(
   parameter int N_SLOTS = DEF_N_SLOTS,
   parameter int SEL_W   = $clog2(N_SLOTS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   input  logic               sync,
   output logic [SEL_W-1:0]   slot,
   output logic [N_SLOTS-1:0] dout,
   output logic               dout_valid,
   output logic               frame_err
);

   tdm_state_e         state_q;
   logic [N_SLOTS-1:0] shadow_q;
   logic [N_SLOTS-1:0] frame_d;
   logic [N_SLOTS-1:0] dout_q;
   logic               dv_q;
   logic               fe_q;
   logic               cnt_load;
   logic               cnt_inc;
   logic               cnt_last;

   assign cnt_load = din_valid & sync;
   assign cnt_inc  = din_valid & ~sync & (state_q == RECV);

   tdm_slot_counter #(
      .N_SLOTS (N_SLOTS),
      .SEL_W   (SEL_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .slot_o (slot),
      .last_o (cnt_last)
   );

   // Shadow with the current beat merged in; the last beat completes dout.
   always_comb begin
      frame_d       = shadow_q;
      frame_d[slot] = din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT;
         shadow_q <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         fe_q     <= 1'b0;
      end else begin
         dv_q <= 1'b0;
         fe_q <= 1'b0;
         if (din_valid) begin
            unique case (state_q)
               HUNT: begin
                  if (sync) begin
                     shadow_q[0] <= din;
                     state_q     <= RECV;
                  end
               end
               RECV: begin
                  if (sync) begin
                     fe_q        <= 1'b1;
                     shadow_q[0] <= din;
                  end else begin
                     shadow_q <= frame_d;
                     if (cnt_last) begin
                        dout_q  <= frame_d;
                        dv_q    <= 1'b1;
                        state_q <= HUNT;
                     end
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign frame_err  = fe_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Scoreboard bench for tdm_demux_1to8: stimulus pushes expected frames,
// a negedge monitor pops and compares on every dout_valid pulse.
module tb_tdm_demux_1to8;

   logic       clk;
   logic       rst;
   logic       din;
   logic       din_valid;
   logic       sync;
   logic [2:0] slot;
   logic [7:0] dout;
   logic       dout_valid;
   logic       frame_err;

   int         tests;
   int         fails;
   int         cyc;
   int         err_seen;
   logic [7:0] exp_q[$];
   int         dv_cyc[$];

   tdm_demux_1to8 dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .sync       (sync),
      .slot       (slot),
      .dout       (dout),
      .dout_valid (dout_valid),
      .frame_err  (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a frame.
   always @(negedge clk) begin
      if (!rst) begin
         if (dout_valid) begin
            dv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_dout_valid", 32'(dout), 32'hFFFF_FFFF);
            end else begin
               check("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
         end
         if (frame_err) err_seen++;
      end
   end

   task automatic beat(input logic b, input logic s);
      din       = b;
      din_valid = 1'b1;
      sync      = s;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      sync      = 1'b0;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      sync      = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] v, input int gap,
                             output int t0);
      exp_q.push_back(v);
      t0 = cyc;
      for (int k = 0; k < 8; k++) begin
         check("slot_step", 32'(slot), 32'(k));
         beat(v[k], k == 0);
         if (k == 2 && gap > 0) begin
            idle(gap);
            check("slot_gap_hold", 32'(slot), 32'd3);
         end
      end
   endtask

   int         t0;
   int         n;
   logic [7:0] src;

   initial begin
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      err_seen  = 0;
      rst       = 1'b1;
      din       = 1'b0;
      din_valid = 1'b0;
      sync      = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         din       = 1'($urandom);
         din_valid = 1'($urandom);
         sync      = 1'($urandom);
         @(posedge clk);
      end
      #1;
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_slot", 32'(slot), 32'd0);
      check("rst_dv", 32'(dout_valid), 32'd0);
      check("rst_fe", 32'(frame_err), 32'd0);
      rst = 1'b0;
      idle(1);

      // Single contiguous frame
      send_frame(8'hA5, 0, t0);
      check("slot_after_frame", 32'(slot), 32'd0);
      idle(1);
      check("lat_contig", 32'(dv_cyc[$] - t0), 32'd8);
      check("dout_hold", 32'(dout), 32'hA5);

      // Gapped frame
      send_frame(8'h3C, 3, t0);
      idle(1);
      check("lat_gapped", 32'(dv_cyc[$] - t0), 32'd11);

      // Short frame, then resync into 0xFF
      beat(1'b1, 1'b1);
      beat(1'b0, 1'b0);
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);
      check("short_slot", 32'(slot), 32'd4);
      exp_q.push_back(8'hFF);
      beat(1'b1, 1'b1);
      check("short_fe", 32'(frame_err), 32'd1);
      check("short_dout_kept", 32'(dout), 32'h3C);
      check("short_resync_slot", 32'(slot), 32'd1);
      for (int k = 1; k < 8; k++) beat(1'b1, 1'b0);
      idle(1);

      // HUNT ignores unsynced beats
      for (int k = 0; k < 5; k++) beat(1'b1, 1'b0);
      check("hunt_slot", 32'(slot), 32'd0);
      check("hunt_dout", 32'(dout), 32'hFF);

      // Back-to-back frames
      send_frame(8'h01, 0, t0);
      send_frame(8'h80, 0, t0);
      idle(2);
      n = dv_cyc.size();
      if (n >= 2) check("b2b_spacing", 32'(dv_cyc[n-1] - dv_cyc[n-2]), 32'd8);
      else check("b2b_pulses", 32'(n), 32'd2);

      // Mid-frame reset at slot 5
      for (int k = 0; k < 5; k++) beat(1'b1, k == 0);
      check("pre_rst_slot", 32'(slot), 32'd5);
      rst       = 1'b1;
      din       = 1'b1;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      din_valid = 1'b0;
      check("midrst_dout", 32'(dout), 32'h00);
      check("midrst_slot", 32'(slot), 32'd0);
      check("midrst_dv", 32'(dout_valid), 32'd0);
      send_frame(8'h5A, 0, t0);
      idle(1);

      // Loopback through an 8:1 mux selected by slot
      src = 8'hC3;
      exp_q.push_back(src);
      for (int k = 0; k < 8; k++) begin
         din       = src[slot];
         din_valid = 1'b1;
         sync      = (k == 0);
         @(posedge clk);
         #1;
      end
      idle(2);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("frame_err_count", 32'(err_seen), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1to8.md
# tdm_demux_1to8

Sequential 1-to-N time-division demultiplexer and deserializer, the receive-side counterpart of the ALU's 8:1 multiplexer. It takes one serial bit per valid beat, steers beat k into output bit k, and presents the assembled word once a full frame has arrived. The `slot` output uses the same {S2,S1,S0} select encoding as the 8:1 multiplexer. Driving that mux's selects from `slot` and feeding its `O0` into `din` therefore gives a loopback path: the mux output returns to its source word.

## Interface
Parameters:
- `N_SLOTS`, default 8: slots per frame; power of two, 2..256.
- `SEL_W`, default $clog2(N_SLOTS): width of the slot index.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `din`  in  1  serial data bit for the current beat.
- `din_valid`  in  1  qualifies `din` and `sync`; when low, all state holds.
- `sync`  in  1  marks this beat as slot 0 of a frame; only meaningful while `din_valid` is high.
- `slot`  out  SEL_W  index of the next beat to be accepted; bits map to {S2,S1,S0}.
- `dout`  out  N_SLOTS  last completed frame; bit k holds slot k.
- `dout_valid`  out  1  single-cycle pulse when `dout` updates.
- `frame_err`  out  1  single-cycle pulse when a partial frame is dropped.

## Operation
- Two-state FSM: HUNT and RECV. An internal shadow register of N_SLOTS bits collects the frame.
- Reset state: FSM in HUNT; `slot`=0, shadow=0, `dout`=0, `dout_valid`=0, `frame_err`=0.
- HUNT:
  - A beat without `sync` is ignored.
  - A beat with `sync`: shadow[0]<=`din`, `slot`<=1, go to RECV.
- RECV, beat without `sync`:
  - shadow[`slot`]<=`din`, `slot`<=`slot`+1.
  - If `slot`==N_SLOTS-1: `dout`<={`din`, shadow[N_SLOTS-2:0]}, pulse `dout_valid`, `slot`<=0, go to HUNT.
- RECV, beat with `sync` (any slot, including N_SLOTS-1):
  - Pulse `frame_err` and discard the partial frame; `dout` is unchanged.
  - This beat becomes slot 0 of a new frame: shadow[0]<=`din`, `slot`<=1, stay in RECV.
- Back-to-back frames: a `sync` beat on the cycle after frame completion is accepted as slot 0 with no lost cycle.
- Unused shadow bits need not be cleared between frames; `dout` only ever reflects complete frames.

## Timing
- One beat is accepted per cycle while `din_valid`=1. Gaps of any length are allowed; state and `slot` hold during gaps.
- `dout` and `dout_valid` are registered. They change on the edge that samples the last beat, so they are visible in the cycle after that beat is presented. Minimum frame latency is N_SLOTS cycles from the `sync` beat to `dout_valid`.
- `dout` holds its value until the next completed frame.
- `dout_valid` and `frame_err` are high for exactly one cycle per event. They are never high in the same cycle, because a `sync` beat cannot complete a frame.
- `slot` is registered and updates on the accepting edge. It is 0 in HUNT and 1..N_SLOTS-1 in RECV.
- If `rst` is high on an edge, it overrides every other input on that edge. Reset mid-frame discards the partial frame, clears `dout`, and suppresses any pending `dout_valid` or `frame_err`.

## Structure
- Shared package `alu_mux_pkg` holds:
  - the `N_SLOTS` default (8) and `SEL_W` constant;
  - the FSM state enum {HUNT, RECV}.
  The 8:1 mux testbenches use the same package for slot encoding.
- One sub-module, `tdm_slot_counter`: an SEL_W-bit counter with load-to-1 on `sync`, increment on beat, clear on wrap and reset, and a last-slot flag. The top level holds the FSM, shadow register and output registers.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with random `din`, `din_valid`, `sync` -> `dout`=0x00, `slot`=0, no pulses.
- **Single frame:** `sync`=1 on the first beat, then 8 contiguous beats with `din` = 1,0,1,0,0,1,0,1 -> `dout`=0xA5 and one `dout_valid` pulse the cycle after beat 7. `slot` steps 0..7 and then reads 0.
- **Gapped frame:** 8 beats spelling 0x3C with `din_valid` low for 3 cycles between beats 2 and 3 -> `dout`=0x3C, `dout_valid` 3 cycles later than the contiguous case, `slot` holds at 3 during the gap.
- **Short frame:** 4 beats, then `sync` with a new frame 0xFF -> `frame_err` pulses once, `dout` keeps its old value, then `dout`=0xFF follows.
- **HUNT filtering and back-to-back:** 5 beats without `sync` -> ignored. Then frames 0x01 and 0x80 back-to-back -> two `dout_valid` pulses exactly 8 cycles apart.
- **Mid-frame reset and loopback:**
  - Assert `rst` at slot 5 -> partial frame lost, `dout`=0x00; the next frame 0x5A is received correctly.
  - Drive the 8:1 mux selects from `slot` with all eight mux inputs set to 0xC3 -> `dout`=0xC3.
